param_mod_counter: RTL and testbench

PARAM_MOD_COUNTER -- requirements
Module: param_mod_counter

---
 rtl/param_mod_counter_pkg.sv | 13 +
 rtl/param_mod_counter_epoch.sv | 20 ++
 rtl/param_mod_counter.sv | 122 ++++++++++++
 tb/tb_param_mod_counter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_mod_counter_pkg.sv
// Shared types and default sizing for the modulo counter.
package param_mod_counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_mode_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 12;
  localparam int DEF_EPOCH_W = 8;

endpackage

// File: rtl/param_mod_counter_epoch.sv
// Wrap tally: counts wrap events since reset, rolling over at 2**EPOCH_W.
module mod_cnt_epoch #(
  parameter int EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [EPOCH_W-1:0] epoch
);

  // Tally register, advanced by one on each wrap event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch <= '0;
    end else if (inc) begin
      epoch <= epoch + EPOCH_W'(1);
    end
  end

endmodule

// File: rtl/param_mod_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, terminal count,
// wrap pulse, out-of-range load flag and a wrap tally.
// Build option: define PARAM_MOD_COUNTER_SAT_EN to pin the count at its
// limits instead of wrapping (wrap then pulses while pinned, epoch frozen).
module param_mod_counter
  import param_mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS,
  parameter int EPOCH_W = DEF_EPOCH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic               mode,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               tc,
  output logic               wrap,
  output logic               load_err,
  output logic [EPOCH_W-1:0] epoch
);

  // One extra bit so MODULUS = 2**WIDTH is representable in compares.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  cnt_mode_e        mode_e;
  logic [WIDTH:0]   din_ext;
  logic [WIDTH:0]   up_ext;
  logic [WIDTH:0]   dn_ext;
  logic             up_wrap;
  logic             dn_wrap;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_d;
  logic             err_d;
  logic             epoch_inc;

  assign mode_e  = cnt_mode_e'(mode);
  assign din_ext = {1'b0, data_in};
  assign up_ext  = {1'b0, data_out} + (WIDTH+1)'(1);
  assign dn_ext  = {1'b0, data_out} - (WIDTH+1)'(1);
  // Stepping past the top reaches MODULUS; stepping below zero borrows.
  assign up_wrap = (up_ext == MOD_EXT);
  assign dn_wrap = dn_ext[WIDTH];

  // Terminal count follows the current mode immediately.
  always_comb begin
    tc = 1'b0;
    if (mode_e == CNT_UP) begin
      tc = (data_out == CNT_MAX);
    end else begin
      tc = (data_out == '0);
    end
  end

  // Next count: load beats enable, enable beats hold.
  always_comb begin
    cnt_d     = data_out;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    epoch_inc = 1'b0;
    if (load) begin
      if (din_ext < MOD_EXT) begin
        cnt_d = data_in;
      end else begin
        cnt_d = CNT_MAX;
        err_d = 1'b1;
      end
    end else if (en) begin
      if (mode_e == CNT_UP) begin
        if (up_wrap) begin
          wrap_d = 1'b1;
`ifdef PARAM_MOD_COUNTER_SAT_EN
          cnt_d = CNT_MAX;
`else
          cnt_d     = '0;
          epoch_inc = 1'b1;
`endif
        end else begin
          cnt_d = up_ext[WIDTH-1:0];
        end
      end else begin
        if (dn_wrap) begin
          wrap_d = 1'b1;
`ifdef PARAM_MOD_COUNTER_SAT_EN
          cnt_d = '0;
`else
          cnt_d     = CNT_MAX;
          epoch_inc = 1'b1;
`endif
        end else begin
          cnt_d = dn_ext[WIDTH-1:0];
        end
      end
    end
  end

  // Count and one-cycle status pulses; reset drops any pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      data_out <= cnt_d;
      wrap     <= wrap_d;
      load_err <= err_d;
    end
  end

  mod_cnt_epoch #(
    .EPOCH_W (EPOCH_W)
  ) u_epoch (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (epoch_inc),
    .epoch (epoch)
  );

endmodule

// File: tb/tb_param_mod_counter.sv
// Self-checking bench for param_mod_counter (default parameters).
module tb_param_mod_counter;

  localparam int W = 4;
  localparam int M = 12;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic         mode;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         tc;
  logic         wrap;
  logic         load_err;
  logic [E-1:0] epoch;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int m_cnt;
  int m_epoch;
  bit m_wrap;
  bit m_err;

  typedef struct {
    bit ld; bit e; bit md; int din;
    int out; bit wr; bit er; bit tcv; int ep;
  } vec_t;

  vec_t tbl [14];

  param_mod_counter #(.WIDTH(W), .MODULUS(M), .EPOCH_W(E)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .mode     (mode),
    .data_in  (data_in),
    .data_out (data_out),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err),
    .epoch    (epoch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_epoch = 0; m_wrap = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit ld, bit e, bit md, int din);
    int nxt;
    m_wrap = 0;
    m_err  = 0;
    if (ld) begin
      if (din < M) m_cnt = din;
      else begin m_cnt = M - 1; m_err = 1; end
    end else if (e) begin
      nxt = md ? m_cnt + 1 : m_cnt - 1;
      if (nxt < 0 || nxt >= M) begin
        m_wrap = 1;
`ifdef PARAM_MOD_COUNTER_SAT_EN
        m_cnt = md ? M - 1 : 0;
`else
        m_cnt   = (nxt + M) % M;
        m_epoch = (m_epoch + 1) % (1 << E);
`endif
      end else begin
        m_cnt = nxt;
      end
    end
  endfunction

  task automatic drive(input bit ld, input bit e, input bit md, input int din);
    load = ld; en = e; mode = md; data_in = W'(din);
    @(posedge clk);
    model_step(ld, e, md, din);
    #1;
  endtask

  task automatic chk_model(input string tag);
    int exp_tc;
    exp_tc = mode ? int'(m_cnt == M - 1) : int'(m_cnt == 0);
    chk({tag, " data_out"}, int'(data_out), m_cnt);
    chk({tag, " wrap"},     int'(wrap),     int'(m_wrap));
    chk({tag, " load_err"}, int'(load_err), int'(m_err));
    chk({tag, " epoch"},    int'(epoch),    m_epoch);
    chk({tag, " tc"},       int'(tc),       exp_tc);
  endtask

  task automatic do_reset();
    load = 0; en = 0; mode = 1; data_in = '0;
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    chk("reset data_out", int'(data_out), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; mode = 1; data_in = '0;
    model_reset();
    #3;
    chk("por data_out", int'(data_out), 0);
    chk("por wrap",     int'(wrap), 0);
    chk("por load_err", int'(load_err), 0);
    chk("por epoch",    int'(epoch), 0);
    @(negedge clk);
    rst_n = 1;

`ifndef PARAM_MOD_COUNTER_SAT_EN
    // ld e md din | out wr er tc ep
    tbl[0]  = '{1, 0, 1, 14, 11, 0, 1, 1, 0};
    tbl[1]  = '{1, 0, 1,  5,  5, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1,  0,  6, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 11, 11, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 1,  2,  2, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 11, 11, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 1,  0,  0, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 0,  0,  0, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 0,  0, 11, 1, 0, 0, 2};
    tbl[9]  = '{0, 1, 0,  0, 10, 0, 0, 0, 2};
    tbl[10] = '{0, 1, 1,  0, 11, 0, 0, 1, 2};
    tbl[11] = '{1, 0, 0, 15, 11, 0, 1, 0, 2};
    tbl[12] = '{0, 0, 0,  0, 11, 0, 0, 0, 2};
    tbl[13] = '{1, 0, 0,  0,  0, 0, 0, 1, 2};
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ld, tbl[i].e, tbl[i].md, tbl[i].din);
      chk($sformatf("vec%0d data_out", i), int'(data_out), tbl[i].out);
      chk($sformatf("vec%0d wrap", i),     int'(wrap),     int'(tbl[i].wr));
      chk($sformatf("vec%0d load_err", i), int'(load_err), int'(tbl[i].er));
      chk($sformatf("vec%0d tc", i),       int'(tc),       int'(tbl[i].tcv));
      chk($sformatf("vec%0d epoch", i),    int'(epoch),    tbl[i].ep);
    end

    // Up-count wrap from reset
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      drive(0, 1, 1, 0);
      chk($sformatf("up%0d data_out", k), int'(data_out), k % M);
      chk($sformatf("up%0d wrap", k),     int'(wrap),     int'(k == 12));
      chk($sformatf("up%0d epoch", k),    int'(epoch),    (k >= 12) ? 1 : 0);
    end

    // Down-count wrap after load 3
    drive(1, 0, 0, 3);
    chk("dn load", int'(data_out), 3);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 0, 0);
      chk($sformatf("dn%0d data_out", k), int'(data_out), (k < 4) ? 3 - k : 11);
      chk($sformatf("dn%0d tc", k),       int'(tc),       int'(k == 3));
      chk($sformatf("dn%0d wrap", k),     int'(wrap),     int'(k == 4));
    end
    chk("dn epoch", int'(epoch), 2);
`else
    // Saturating up-count
    for (int k = 1; k <= 15; k++) begin
      drive(0, 1, 1, 0);
      chk($sformatf("sat%0d data_out", k), int'(data_out), (k < 11) ? k : 11);
      chk($sformatf("sat%0d wrap", k),     int'(wrap),     int'(k >= 12));
      chk($sformatf("sat%0d epoch", k),    int'(epoch),    0);
    end
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("satdn data_out", int'(data_out), 0);
    chk("satdn wrap",     int'(wrap), 1);
`endif

    // Async reset mid-cycle at count 7, then resume from 0
    drive(1, 0, 1, 7);
    drive(0, 0, 1, 0);
    chk("pre-rst data_out", int'(data_out), 7);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("async data_out", int'(data_out), 0);
    chk("async epoch",    int'(epoch), 0);
    @(negedge clk);
    rst_n = 1;
    drive(0, 1, 1, 0);
    chk("resume data_out", int'(data_out), 1);

    // Reset discards an in-flight load_err pulse
    drive(1, 0, 1, 14);
    chk("inflight err set", int'(load_err), 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("inflight err cleared", int'(load_err), 0);
    chk("inflight data_out", int'(data_out), 0);
    @(negedge clk);
    rst_n = 1;

    // Reset discards an in-flight wrap pulse
    drive(1, 0, 1, 11);
    drive(0, 1, 1, 0);
    chk("inflight wrap set", int'(wrap), 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("inflight wrap cleared", int'(wrap), 0);
    @(negedge clk);
    rst_n = 1;

    // Randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, (1 << W) - 1)));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
